// File: rtl/load_store_unit.sv
// load_store_unit: turns RISC-V load/store requests into single-port memory accesses.
// mem_wwidth: 0 = byte, 1 = half, 2 = word. Define LSU_MISALIGNED_SPLIT_EN to split misaligned accesses into byte accesses.
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic [XLEN-1:0] mem_addr,
  output logic [1:0]      mem_wwidth,
  output logic            mem_wenable,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);
  localparam logic [1:0] WRITE_BYTE = 2'b00;

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, FAULT, SPLIT, RESP} state_t;

  state_t          state, state_next;
  logic            is_store_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            fault_q;

  function automatic logic legal_op(input logic is_store, input logic [2:0] funct3);
    if (is_store) return (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    return (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    return ((funct3[1:0] == 2'b01) && addr_lo[0]) || ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [2:0] funct3, input logic [XLEN-1:0] data);
    case (funct3)
      3'b000:  return {{(XLEN-8){data[7]}}, data[7:0]};
      3'b001:  return {{(XLEN-16){data[15]}}, data[15:0]};
      3'b100:  return {{(XLEN-8){1'b0}}, data[7:0]};
      3'b101:  return {{(XLEN-16){1'b0}}, data[15:0]};
      default: return data;
    endcase
  endfunction

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
  logic [1:0]      idx_q;
  logic            phase_q;
  logic [XLEN-1:0] asm_q;
  logic [XLEN-1:0] asm_next;
  logic            last_byte;

  // Halves split into 2 bytes, words into 4; bytes assemble little-endian.
  assign last_byte = (idx_q == (funct3_q[1] ? 2'd3 : 2'd1));
  assign asm_next  = asm_q | ({{(XLEN-8){1'b0}}, mem_rdata[7:0]} << {idx_q, 3'b000});
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_addr    = '0;
    mem_wwidth  = WRITE_BYTE;
    mem_wenable = 1'b0;
    mem_wdata   = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!legal_op(req_is_store, req_funct3))        state_next = FAULT;
          else if (misaligned(req_funct3, req_addr[1:0])) state_next = SPLIT_EN ? SPLIT : FAULT;
          else                                            state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_addr    = addr_q;
        mem_wwidth  = funct3_q[1:0];
        mem_wenable = is_store_q;
        mem_wdata   = is_store_q ? wdata_q : '0;
        state_next  = is_store_q ? RESP : CAPTURE;
      end
      CAPTURE: state_next = RESP;
      FAULT:   state_next = RESP;
`ifdef LSU_MISALIGNED_SPLIT_EN
      SPLIT: begin
        mem_addr = addr_q + XLEN'(idx_q);
        if (is_store_q) begin
          mem_wenable = 1'b1;
          mem_wdata   = {{(XLEN-8){1'b0}}, wdata_q[{idx_q, 3'b000} +: 8]};
          if (last_byte) state_next = RESP;
        end else if (phase_q && last_byte) begin
          state_next = RESP;
        end
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          is_store_q <= req_is_store;
          funct3_q   <= req_funct3;
          addr_q     <= req_addr;
          wdata_q    <= req_wdata;
          rdata_q    <= '0;
          fault_q    <= (state_next == FAULT);
        end
        CAPTURE: rdata_q <= extend(funct3_q, mem_rdata);
`ifdef LSU_MISALIGNED_SPLIT_EN
        SPLIT: if (!is_store_q && phase_q && last_byte) rdata_q <= extend(funct3_q, asm_next);
`endif
        default: ;
      endcase
    end
  end

`ifdef LSU_MISALIGNED_SPLIT_EN
  // Split loads alternate issue (phase 0) and capture (phase 1) per byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      phase_q <= 1'b0;
      asm_q   <= '0;
    end else if (state == IDLE) begin
      idx_q   <= '0;
      phase_q <= 1'b0;
      asm_q   <= '0;
    end else if (state == SPLIT) begin
      if (is_store_q) begin
        idx_q <= idx_q + 2'd1;
      end else begin
        phase_q <= !phase_q;
        if (phase_q) begin
          asm_q <= asm_next;
          idx_q <= idx_q + 2'd1;
        end
      end
    end
  end
`endif

  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory device, transaction-level reference model,
// per-cycle compare process, directed literal checks and randomized traffic.
module tb_load_store_unit;
  localparam int XLEN = 32;
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [1:0]  mem_wwidth;
  logic        mem_wenable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_wwidth(mem_wwidth), .mem_wenable(mem_wenable),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37) + 11);
  endfunction

  // Memory device: synchronous write, read data follows the address registered last edge.
  logic [7:0]  phys [256];
  logic [31:0] raddr = '0;
  initial begin
    for (int i = 0; i < 256; i++) phys[i] = init_byte(i);
    forever begin
      @(posedge clk);
      if (mem_wenable)
        for (int i = 0; i < 4; i++)
          if (i < (1 << mem_wwidth)) phys[8'(mem_addr + 32'(i))] <= mem_wdata[8*i +: 8];
      raddr <= mem_addr;
    end
  end
  assign mem_rdata = {phys[8'(raddr + 32'd3)], phys[8'(raddr + 32'd2)],
                      phys[8'(raddr + 32'd1)], phys[raddr[7:0]]};

  // Reference model state
  logic [7:0]  ref_mem [256];
  bit          active = 1'b0;
  int          k = 0;
  int          lat = 0;
  logic [31:0] exp_rd = '0;
  logic        exp_flt = 1'b0;
  int          q_wk[$];
  logic [31:0] q_wa[$];
  logic [31:0] q_wd[$];
  logic [1:0]  q_ww[$];
  bit          q_sp[$];
  int          wr_cnt = 0;
  logic [1:0]  last_ww = '0;

  task automatic predict(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int size;
    bit legal, mis, split;
    logic [31:0] v;
    size  = 1 << f3[1:0];
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis   = (a % size) != 0;
    split = legal && mis && SPLIT;
    exp_flt = !legal || (mis && !SPLIT);
    exp_rd  = '0;
    if (exp_flt) begin
      lat = 1;
    end else if (st) begin
      lat = split ? size : 1;
      for (int i = 0; i < size; i++) begin
        ref_mem[8'(a + 32'(i))] = wd[8*i +: 8];
        if (split) begin
          q_wk.push_back(i); q_wa.push_back(a + 32'(i));
          q_wd.push_back({24'h0, wd[8*i +: 8]}); q_ww.push_back(2'd0); q_sp.push_back(1'b1);
        end
      end
      if (!split) begin
        q_wk.push_back(0); q_wa.push_back(a); q_wd.push_back(wd);
        q_ww.push_back(f3[1:0]); q_sp.push_back(1'b0);
      end
    end else begin
      lat = split ? 2 * size : 2;
      v = '0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_mem[8'(a + 32'(i))]) << (8 * i));
      if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
      exp_rd = v;
    end
  endtask

  // Compare process: every falling edge checks the DUT against the model.
  initial begin
    int wk;
    logic [31:0] wa, wdx;
    logic [1:0] ww;
    bit sp;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
        q_wk.delete(); q_wa.delete(); q_wd.delete(); q_ww.delete(); q_sp.delete();
      end else if (!active) begin
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_resp_valid", 32'(resp_valid), 32'd0);
        chk("idle_mem_wenable", 32'(mem_wenable), 32'd0);
        chk("idle_mem_addr", mem_addr, 32'd0);
        chk("idle_mem_wwidth", 32'(mem_wwidth), 32'd0);
        chk("idle_mem_wdata", mem_wdata, 32'd0);
      end else begin
        k++;
        chk("busy_req_ready", 32'(req_ready), 32'd0);
        chk("resp_valid_timing", 32'(resp_valid), 32'(k >= lat));
        if (resp_valid) begin
          chk("resp_rdata", resp_rdata, exp_rd);
          chk("resp_fault", 32'(resp_fault), 32'(exp_flt));
        end
        if (mem_wenable) begin
          wr_cnt++;
          last_ww = mem_wwidth;
          chk("write_expected", 32'(q_wk.size() != 0), 32'd1);
          if (q_wk.size() != 0) begin
            wk = q_wk.pop_front(); wa = q_wa.pop_front(); wdx = q_wd.pop_front();
            ww = q_ww.pop_front(); sp = q_sp.pop_front();
            chk("write_cycle", 32'(k), 32'(wk));
            chk("write_addr", mem_addr, wa);
            chk("write_width", 32'(mem_wwidth), 32'(ww));
            if (sp) chk("write_byte_data", 32'(mem_wdata[7:0]), wdx);
            else    chk("write_data", mem_wdata, wdx);
          end
        end
        if (resp_valid && resp_ready) begin
          chk("writes_all_done", 32'(q_wk.size()), 32'd0);
          active = 1'b0;
        end
      end
      if (rst_n && !active && req_valid && req_ready) begin
        predict(req_is_store, req_funct3, req_addr, req_wdata);
        active = 1'b1;
        k = -1;
      end
    end
  end

  // Optional request armed during a held response; it must wait for the handshake.
  bit          arm = 1'b0;
  bit          arm_st;
  logic [2:0]  arm_f3;
  logic [31:0] arm_a, arm_wd;

  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd, output logic flt);
    int n;
    bit acc;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    resp_ready = 1'b0;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      acc = req_ready;
      @(posedge clk); #1;
      n++;
    end
    rd = '0; flt = 1'b0;
    chk("accept_in_time", 32'(acc), 32'd1);
    if (!acc) begin
      req_valid = 1'b0;
      return;
    end
    req_valid = 1'b0;
    req_is_store = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    resp_ready = (hold == 0);
    n = 0;
    while (!resp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("resp_in_time", 32'(resp_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      if (arm) begin
        req_valid = 1'b1; req_is_store = arm_st; req_funct3 = arm_f3; req_addr = arm_a; req_wdata = arm_wd;
      end
      @(posedge clk); #1;
    end
    rd = resp_rdata; flt = resp_fault;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic flt;
    logic [2:0] lf [5];
    logic [7:0] snap;
    int mism;
    bit st;
    logic [2:0] f3;
    logic [31:0] a;
    lf[0] = 3'd0; lf[1] = 3'd1; lf[2] = 3'd2; lf[3] = 3'd4; lf[4] = 3'd5;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);
    chk("rst_mem_wenable", 32'(mem_wenable), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    wr_cnt = 0;
    access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, flt);
    chk("sw_wenable_cycles", 32'(wr_cnt), 32'd1);
    chk("sw_width_word", 32'(last_ww), 32'd2);
    chk("sw_rdata_zero", rd, 32'd0);
    access(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, flt);
    chk("lw_deadbeef", rd, 32'hDEADBEEF);

    access(1'b1, 3'b000, 32'h21, 32'h80, 0, rd, flt);
    access(1'b1, 3'b000, 32'h20, 32'h01, 1, rd, flt);
    access(1'b0, 3'b000, 32'h21, 32'h0, 0, rd, flt);
    chk("lb_sign", rd, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h21, 32'h0, 2, rd, flt);
    chk("lbu_zero", rd, 32'h00000080);
    access(1'b0, 3'b001, 32'h20, 32'h0, 0, rd, flt);
    chk("lh_sign", rd, 32'hFFFF8001);

    wr_cnt = 0;
    access(1'b0, 3'b011, 32'h20, 32'h0, 0, rd, flt);
    chk("illegal_f3_fault", 32'(flt), 32'd1);
    chk("illegal_f3_rdata", rd, 32'd0);

`ifndef LSU_MISALIGNED_SPLIT_EN
    snap = phys[8'h22];
    wr_cnt = 0;
    access(1'b1, 3'b001, 32'h21, 32'h0000BEEF, 0, rd, flt);
    chk("sh_mis_fault", 32'(flt), 32'd1);
    chk("sh_mis_rdata", rd, 32'd0);
    chk("sh_mis_no_write", 32'(wr_cnt), 32'd0);
    chk("sh_mis_mem21", 32'(phys[8'h21]), 32'h80);
    chk("sh_mis_mem22", 32'(phys[8'h22]), 32'(snap));
`else
    wr_cnt = 0;
    access(1'b1, 3'b010, 32'h3, 32'h44332211, 0, rd, flt);
    chk("sw_split_writes", 32'(wr_cnt), 32'd4);
    chk("sw_split_width", 32'(last_ww), 32'd0);
    chk("sw_split_fault", 32'(flt), 32'd0);
    access(1'b0, 3'b010, 32'h3, 32'h0, 0, rd, flt);
    chk("lw_split_data", rd, 32'h44332211);
    chk("lw_split_fault", 32'(flt), 32'd0);
    access(1'b0, 3'b001, 32'h5, 32'h0, 0, rd, flt);
    chk("lh_split_data", rd, 32'h00004433);
`endif

    // Held response with a request waiting behind it.
    arm = 1'b1; arm_st = 1'b0; arm_f3 = 3'b010; arm_a = 32'h10; arm_wd = 32'h0;
    access(1'b0, 3'b001, 32'h20, 32'h0, 5, rd, flt);
    chk("held_lh", rd, 32'hFFFF8001);
    arm = 1'b0;
    access(arm_st, arm_f3, arm_a, arm_wd, 0, rd, flt);
    chk("armed_lw", rd, 32'hDEADBEEF);

    // Reset while the load sits in CAPTURE.
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    access(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, flt);
    chk("after_rst_lw", rd, 32'hDEADBEEF);

    for (int t = 0; t < 400; t++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = st ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 4)];
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else a = 32'($urandom_range(0, 255));
      access(st, f3, a, $urandom, $urandom_range(0, 3), rd, flt);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (2) @(posedge clk);
    mism = 0;
    for (int i = 0; i < 256; i++) if (phys[i] !== ref_mem[i]) mism++;
    chk("mem_image_diff_bytes", 32'(mism), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
